request_sender: RTL and testbench

REQUEST_SENDER -- requirements
Module: request_sender

---
 rtl/request_sender.sv | 136 +++++++++++++
 tb/tb_request_sender.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/request_sender.sv
// request_sender: sends up to two frames (P then Q) to a receiving controller.
// Each frame is a one-cycle request strobe, a one-cycle confirm strobe and a
// gap of GAP_CYCLES idle cycles. A one-cycle done pulse ends the sequence.
//
// Ports:
//   clock    - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - single-cycle pulse requesting a sequence (ignored unless idle)
//   enP/enQ  - enable the P / Q frame
//   valueP/Q - 7-bit payloads for the P / Q frame
//   request  - frame-request strobe (registered)
//   confirm  - frame-confirm strobe (registered)
//   outData  - {payload[6:0], sel}, sel=1 for P, sel=0 for Q
//   busy     - high whenever the FSM is not idle
//   done     - one-cycle pulse when a sequence completes
module request_sender #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       enP,
    input  logic       enQ,
    input  logic [6:0] valueP,
    input  logic [6:0] valueQ,
    output logic       request,
    output logic       confirm,
    output logic [7:0] outData,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] GapInit = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReqP,
        StConfP,
        StGapP,
        StReqQ,
        StConfQ,
        StGapQ,
        StDone
    } state_e;

    state_e     state;
    logic [3:0] gap_cnt;
    // The P payload and enable are consumed at capture time (the P frame is
    // loaded straight into outData), so only the Q side needs holding copies.
    logic       cap_en_q;
    logic [6:0] cap_value_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            gap_cnt     <= 4'd0;
            cap_en_q    <= 1'b0;
            cap_value_q <= 7'd0;
            request     <= 1'b0;
            confirm     <= 1'b0;
            outData     <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            request <= 1'b0;
            confirm <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && (enP || enQ)) begin
                        cap_en_q    <= enQ;
                        cap_value_q <= valueQ;
                        request     <= 1'b1;
                        busy        <= 1'b1;
                        if (enP) begin
                            state   <= StReqP;
                            outData <= {valueP, 1'b1};
                        end else begin
                            state   <= StReqQ;
                            outData <= {valueQ, 1'b0};
                        end
                    end
                end
                StReqP: begin
                    state   <= StConfP;
                    confirm <= 1'b1;
                end
                StConfP: begin
                    state   <= StGapP;
                    gap_cnt <= GapInit;
                end
                StGapP: begin
                    if (gap_cnt == 4'd0) begin
                        if (cap_en_q) begin
                            state   <= StReqQ;
                            request <= 1'b1;
                            outData <= {cap_value_q, 1'b0};
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                StReqQ: begin
                    state   <= StConfQ;
                    confirm <= 1'b1;
                end
                StConfQ: begin
                    state   <= StGapQ;
                    gap_cnt <= GapInit;
                end
                StGapQ: begin
                    if (gap_cnt == 4'd0) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                StDone: begin
                    // Any start seen here is dropped; idle is entered cleanly.
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_sender.sv
// Testbench for request_sender: a per-cycle vector table against a
// GAP_CYCLES=1 instance, plus a hand-written timing sequence against a
// GAP_CYCLES=3 instance.
module tb_request_sender;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       enP;
    logic       enQ;
    logic [6:0] valueP;
    logic [6:0] valueQ;

    logic       req1, conf1, busy1, done1;
    logic [7:0] data1;
    logic       req3, conf3, busy3, done3;
    logic [7:0] data3;

    int tests;
    int fails;
    int overlap;

    request_sender #(.GAP_CYCLES(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .enP     (enP),
        .enQ     (enQ),
        .valueP  (valueP),
        .valueQ  (valueQ),
        .request (req1),
        .confirm (conf1),
        .outData (data1),
        .busy    (busy1),
        .done    (done1)
    );

    request_sender #(.GAP_CYCLES(3)) dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .enP     (enP),
        .enQ     (enQ),
        .valueP  (valueP),
        .valueQ  (valueQ),
        .request (req3),
        .confirm (conf3),
        .outData (data3),
        .busy    (busy3),
        .done    (done3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ((req1 && conf1) || (req3 && conf3)) overlap++;
    end

    typedef struct {
        logic       rst_n;
        logic       st;
        logic       ep;
        logic       eq;
        logic [6:0] vp;
        logic [6:0] vq;
        logic       e_req;
        logic       e_conf;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic p, input logic q,
                       input logic [6:0] vp, input logic [6:0] vq,
                       input logic er, input logic ec, input logic [7:0] ed,
                       input logic eb, input logic edn);
        vec_t v;
        v.rst_n = r; v.st = s; v.ep = p; v.eq = q; v.vp = vp; v.vq = vq;
        v.e_req = er; v.e_conf = ec; v.e_data = ed; v.e_busy = eb; v.e_done = edn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int busy_cnt;
    int done_at;
    int req_pos[$];
    int conf_pos[$];

    initial begin
        tests = 0; fails = 0; overlap = 0;
        reset_n = 1'b0; start = 1'b0; enP = 1'b0; enQ = 1'b0;
        valueP = 7'h00; valueQ = 7'h00;

        //  rst st ep eq  vP     vQ   | req conf data  busy done
        add(0, 0, 0, 0, 7'h00, 7'h00, 0, 0, 8'h00, 0, 0); // reset
        add(1, 0, 0, 0, 7'h00, 7'h00, 0, 0, 8'h00, 0, 0); // idle
        add(1, 1, 1, 1, 7'h55, 7'h2A, 1, 0, 8'hAB, 1, 0); // REQ_P
        add(1, 0, 1, 1, 7'h00, 7'h2A, 0, 1, 8'hAB, 1, 0); // CONF_P, valueP changed
        add(1, 1, 1, 1, 7'h00, 7'h2A, 0, 0, 8'hAB, 1, 0); // start during CONF_P -> GAP_P
        add(1, 0, 1, 1, 7'h00, 7'h00, 1, 0, 8'h54, 1, 0); // REQ_Q
        add(1, 0, 1, 1, 7'h00, 7'h00, 0, 1, 8'h54, 1, 0); // CONF_Q
        add(1, 1, 1, 1, 7'h00, 7'h00, 0, 0, 8'h54, 1, 0); // GAP_Q
        add(1, 1, 1, 1, 7'h00, 7'h00, 0, 0, 8'h54, 1, 1); // DONE
        add(1, 1, 1, 1, 7'h11, 7'h22, 0, 0, 8'h54, 0, 0); // start during DONE ignored
        add(1, 0, 1, 1, 7'h11, 7'h22, 0, 0, 8'h54, 0, 0); // still idle, nothing queued
        add(1, 1, 0, 1, 7'h00, 7'h7F, 1, 0, 8'hFE, 1, 0); // Q only: REQ_Q
        add(1, 0, 0, 1, 7'h00, 7'h7F, 0, 1, 8'hFE, 1, 0); // CONF_Q
        add(1, 0, 0, 1, 7'h00, 7'h7F, 0, 0, 8'hFE, 1, 0); // GAP_Q
        add(1, 0, 0, 1, 7'h00, 7'h7F, 0, 0, 8'hFE, 1, 1); // DONE
        add(1, 0, 0, 1, 7'h00, 7'h7F, 0, 0, 8'hFE, 0, 0); // idle
        add(1, 1, 0, 0, 7'h12, 7'h34, 0, 0, 8'hFE, 0, 0); // start with 00 ignored
        add(1, 0, 0, 0, 7'h12, 7'h34, 0, 0, 8'hFE, 0, 0); // idle
        add(1, 1, 1, 1, 7'h55, 7'h2A, 1, 0, 8'hAB, 1, 0); // REQ_P
        add(1, 0, 1, 1, 7'h55, 7'h2A, 0, 1, 8'hAB, 1, 0); // CONF_P
        add(1, 0, 1, 1, 7'h55, 7'h2A, 0, 0, 8'hAB, 1, 0); // GAP_P
        add(0, 0, 1, 1, 7'h55, 7'h2A, 0, 0, 8'h00, 0, 0); // reset during GAP_P
        add(1, 0, 1, 1, 7'h55, 7'h2A, 0, 0, 8'h00, 0, 0); // no Q frame after reset
        add(1, 1, 1, 0, 7'h01, 7'h2A, 1, 0, 8'h03, 1, 0); // P only: REQ_P
        add(1, 0, 1, 0, 7'h01, 7'h2A, 0, 1, 8'h03, 1, 0); // CONF_P
        add(1, 0, 1, 0, 7'h01, 7'h2A, 0, 0, 8'h03, 1, 0); // GAP_P
        add(1, 0, 1, 0, 7'h01, 7'h2A, 0, 0, 8'h03, 1, 1); // DONE
        add(1, 0, 1, 0, 7'h01, 7'h2A, 0, 0, 8'h03, 0, 0); // idle

        foreach (vecs[i]) begin
            @(negedge clock);
            reset_n = vecs[i].rst_n;
            start   = vecs[i].st;
            enP     = vecs[i].ep;
            enQ     = vecs[i].eq;
            valueP  = vecs[i].vp;
            valueQ  = vecs[i].vq;
            if (!reset_n) begin
                // Reset must act before any clock edge.
                #1;
                chk($sformatf("v%0d async_req", i), 32'(req1), 32'(1'b0));
                chk($sformatf("v%0d async_conf", i), 32'(conf1), 32'(1'b0));
                chk($sformatf("v%0d async_data", i), 32'(data1), 32'(8'h00));
                chk($sformatf("v%0d async_busy", i), 32'(busy1), 32'(1'b0));
                chk($sformatf("v%0d async_done", i), 32'(done1), 32'(1'b0));
            end
            @(posedge clock);
            #1;
            chk($sformatf("v%0d request", i), 32'(req1), 32'(vecs[i].e_req));
            chk($sformatf("v%0d confirm", i), 32'(conf1), 32'(vecs[i].e_conf));
            chk($sformatf("v%0d outData", i), 32'(data1), 32'(vecs[i].e_data));
            chk($sformatf("v%0d busy", i), 32'(busy1), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d done", i), 32'(done1), 32'(vecs[i].e_done));
        end

        // GAP_CYCLES=3, both frames: 1 + 2*(2+3) = 11 busy cycles.
        @(negedge clock);
        reset_n = 1'b0; start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("g3 reset busy", 32'(busy3), 32'(1'b0));
        chk("g3 reset data", 32'(data3), 32'(8'h00));
        @(negedge clock);
        start = 1'b1; enP = 1'b1; enQ = 1'b1; valueP = 7'h55; valueQ = 7'h2A;
        busy_cnt = 0; done_at = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) start = 1'b0;
            if (busy3) busy_cnt++;
            if (req3) req_pos.push_back(c);
            if (conf3) conf_pos.push_back(c);
            if (c == 1) chk("g3 P frame", 32'(data3), 32'(8'hAB));
            if (c == 6) chk("g3 Q frame", 32'(data3), 32'(8'h54));
            if (c == 4) chk("g3 gap holds frame", 32'(data3), 32'(8'hAB));
            if (done3) begin
                done_at = c;
                break;
            end
        end
        chk("g3 done cycle", 32'(done_at), 32'd11);
        chk("g3 busy cycles", 32'(busy_cnt), 32'd11);
        chk("g3 request count", 32'(req_pos.size()), 32'd2);
        chk("g3 confirm count", 32'(conf_pos.size()), 32'd2);
        if (req_pos.size() == 2) begin
            chk("g3 req P pos", 32'(req_pos[0]), 32'd1);
            chk("g3 req Q pos", 32'(req_pos[1]), 32'd6);
        end
        if (conf_pos.size() == 2) begin
            chk("g3 conf P pos", 32'(conf_pos[0]), 32'd2);
            chk("g3 conf Q pos", 32'(conf_pos[1]), 32'd7);
        end
        @(posedge clock);
        #1;
        chk("g3 idle after done", 32'(busy3), 32'(1'b0));
        chk("g3 done one cycle", 32'(done3), 32'(1'b0));

        chk("request/confirm overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
